// File: rtl/prescaler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prescaler_pkg
// Description : Shared defaults for the multi-channel prescaler and the
//               reset-divisor function that reproduces the legacy
//               /2, /4, /8, /16 outputs (channel k divides by 2^(k+1)).
// Revision    : 1.0 - initial release
// ============================================================================
package prescaler_pkg;

    localparam int N_CH_DEF  = 4;
    localparam int CNT_W_DEF = 16;

    // Reset divisor of channel k. Channel k then matches bit k of a
    // free-running binary counter.
    function automatic int unsigned reset_div(input int k);
        return 32'd1 << (k + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/prescaler_ch.sv
`default_nettype none
// ============================================================================
// Module      : prescaler_ch
// Description : One prescaler channel. Holds the period counter, the active
//               and shadow divisors and the pending flag, and drives the
//               registered square-wave and tick outputs.
// Ports       : clk_i     - clock
//               rstn_i    - asynchronous active-low reset
//               en_i      - run enable (0 freezes the counter)
//               sync_i    - synchronous restart, overrides en_i
//               we_i      - shadow divisor write strobe (already decoded)
//               div_i     - divisor to write; 0 disables the channel
//               clk_o     - divided square wave
//               tick_o    - one-cycle strobe in the last cycle of a period
//               pending_o - a written divisor has not been applied yet
// Revision    : 1.0 - initial release
// ============================================================================
module prescaler_ch
    import prescaler_pkg::*;
#(
    parameter int              CNT_W   = CNT_W_DEF,
    parameter logic [CNT_W-1:0] RST_DIV = CNT_W'(2)
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             en_i,
    input  logic             sync_i,
    input  logic             we_i,
    input  logic [CNT_W-1:0] div_i,
    output logic             clk_o,
    output logic             tick_o,
    output logic             pending_o
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div_act;
    logic [CNT_W-1:0] div_shd;
    logic             pend;
    logic             clk_q;
    logic             tick_q;

    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] act_nxt;
    logic [CNT_W-1:0] shd_nxt;
    logic             pend_nxt;
    logic             clk_nxt;
    logic             tick_nxt;
    logic             disabled;
    logic             wrap;
    logic             apply;

    always_comb begin
        disabled = (div_act == '0);
        wrap     = en_i && !disabled && (cnt == div_act - CNT_W'(1));
        // A disabled channel re-applies its shadow every cycle, so a new
        // divisor takes effect one cycle after it is written, even when
        // frozen. When nothing is pending the shadow equals the active
        // divisor, so an unconditional apply is harmless.
        apply    = sync_i || wrap || disabled;

        cnt_nxt  = cnt;
        act_nxt  = div_act;
        shd_nxt  = div_shd;
        pend_nxt = pend;

        if (apply) begin
            act_nxt  = div_shd;
            pend_nxt = 1'b0;
        end

        if (apply) begin
            cnt_nxt = '0;
        end else if (en_i) begin
            cnt_nxt = cnt + CNT_W'(1);
        end

        // The write lands after the apply decision: a wrap or sync in the
        // same cycle uses the old shadow and the new value stays pending.
        if (we_i) begin
            shd_nxt  = div_i;
            pend_nxt = 1'b1;
        end

        // Outputs are computed from next-state values so the flops line up
        // with the counter without an extra cycle of latency.
        tick_nxt = en_i && !sync_i && (act_nxt != '0) &&
                   (cnt_nxt == act_nxt - CNT_W'(1));
        clk_nxt  = (act_nxt != '0) && (cnt_nxt >= (act_nxt >> 1));
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt     <= '0;
            div_act <= RST_DIV;
            div_shd <= RST_DIV;
            pend    <= 1'b0;
            clk_q   <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            cnt     <= cnt_nxt;
            div_act <= act_nxt;
            div_shd <= shd_nxt;
            pend    <= pend_nxt;
            clk_q   <= clk_nxt;
            tick_q  <= tick_nxt;
        end
    end

    assign clk_o     = clk_q;
    assign tick_o    = tick_q;
    assign pending_o = pend;

endmodule
`default_nettype wire

// File: rtl/prescaler_multi.sv
`default_nettype none
// ============================================================================
// Module      : prescaler_multi
// Description : Multi-channel programmable clock-enable generator. Each
//               channel divides clk_i by a run-time divisor; reset divisors
//               reproduce the legacy /2, /4, /8, /16 prescaler outputs.
// Ports       : clk_i     - clock
//               rstn_i    - asynchronous active-low reset
//               en_i      - global run enable
//               sync_i    - synchronous restart of all channels
//               cfg_we_i  - divisor write strobe
//               cfg_ch_i  - target channel of the write
//               cfg_div_i - divisor value (0 disables the channel)
//               clk_o     - per-channel divided square wave
//               tick_o    - per-channel one-cycle strobe
//               pending_o - per-channel written-but-not-applied flag
// Revision    : 1.0 - initial release
// ============================================================================
module prescaler_multi
    import prescaler_pkg::*;
#(
    parameter int N_CH  = N_CH_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             en_i,
    input  logic             sync_i,
    input  logic             cfg_we_i,
    input  logic [CH_W-1:0]  cfg_ch_i,
    input  logic [CNT_W-1:0] cfg_div_i,
    output logic [N_CH-1:0]  clk_o,
    output logic [N_CH-1:0]  tick_o,
    output logic [N_CH-1:0]  pending_o
);

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        logic we_ch;

        // An index of N_CH or above matches no channel, so such writes
        // are dropped without touching any state.
        assign we_ch = cfg_we_i && (cfg_ch_i == CH_W'(k));

        prescaler_ch #(
            .CNT_W   (CNT_W),
            .RST_DIV (CNT_W'(reset_div(k)))
        ) u_ch (
            .clk_i     (clk_i),
            .rstn_i    (rstn_i),
            .en_i      (en_i),
            .sync_i    (sync_i),
            .we_i      (we_ch),
            .div_i     (cfg_div_i),
            .clk_o     (clk_o[k]),
            .tick_o    (tick_o[k]),
            .pending_o (pending_o[k])
        );
    end

endmodule
`default_nettype wire

// File: doc/prescaler_multi.md
# prescaler_multi

Multi-channel programmable clock-enable generator that supersedes the fixed 4-bit divide-by-2/4/8/16 prescaler. Each of N_CH channels divides clk_i by a run-time programmable integer and provides a square-wave output and a single-cycle tick strobe. New divisors apply glitch-free at the channel's wrap point, and all channels can be phase-aligned with a synchronous restart. Reset divisors reproduce the legacy /2, /4, /8, /16 outputs, so the block is a drop-in replacement.

## Interface
- N_CH, 4: number of channels.
- CNT_W, 16: divisor and counter width; must be ≥ N_CH+1.
- CH_W, $clog2(N_CH) (min 1): channel index width.

- clk_i  in  1  clock.
- rstn_i  in  1  reset, asynchronous, active-low.
- en_i  in  1  global run. 0 freezes all counters.
- sync_i  in  1  synchronous restart of all channels.
- cfg_we_i  in  1  divisor write strobe.
- cfg_ch_i  in  CH_W  target channel of the write.
- cfg_div_i  in  CNT_W  divisor value; 0 disables the channel.
- clk_o  out  N_CH  divided square wave, one bit per channel.
- tick_o  out  N_CH  one-cycle strobe, once per period.
- pending_o  out  N_CH  a written divisor is waiting to apply.

## Operation
- Per-channel state:
  - cnt: CNT_W bits.
  - div_act: active divisor.
  - div_shd: shadow divisor.
  - pend flag.
  - clk_q and tick_q output flops.
- Reset:
  - cnt=0.
  - div_act = div_shd = 2^(k+1) for channel k.
  - pend=0, clk_o=0, tick_o=0.
- Counting, when en_i=1 and div_act=D≥1:
  - cnt steps 0,1,…,D-1, then back to 0.
  - tick_o=1 exactly in cycles where cnt==D-1.
  - clk_o=1 in cycles where cnt ≥ (D>>1).
  - Power-of-two D therefore matches the legacy counter bit (D=2^(k+1) ↔ old bit k).
- D=1: tick_o is constantly 1 and clk_o is constantly 1.
- D=0 (disabled): cnt is held at 0, clk_o=0, tick_o=0.
- en_i=0:
  - cnt and clk_o hold their values.
  - tick_o is forced to 0.
  - Pending loads wait.
- Write (cfg_we_i=1):
  - div_shd[cfg_ch_i] ← cfg_div_i and pend ← 1.
  - If cfg_ch_i ≥ N_CH, the write is ignored.
  - A repeated write before apply overwrites the shadow; the last write wins.
- Apply (div_act ← div_shd, pend ← 0) happens at the first of:
  - (a) the wrap cycle (en_i=1, cnt==div_act-1); cnt then restarts at 0 with the new D.
  - (b) sync_i=1.
  - (c) the channel is disabled (div_act==0): applies on the next cycle regardless of en_i.
- sync_i=1:
  - Next cycle, every channel has cnt=0 and pending shadows applied.
  - tick_o=0 that cycle, and clk_o takes the value for cnt=0 (1 only if D=1).
  - sync_i overrides en_i=0.

## Timing
- clk_o and tick_o are driven directly from flops, computed from next-state cnt/div_act. They never glitch and have no extra latency relative to cnt.
- Write → apply: a write is registered into the shadow at the edge ending its cycle. A wrap or sync in the same cycle as the write uses the previous shadow; the new value applies at the following wrap.
- pending_o rises the cycle after the write and falls the cycle after apply.
- The first wrap after a divisor change has period old-D remainder. Every period after that is exactly new D.
- Reset asserted mid-period: all outputs return to reset values immediately (asynchronous); pending writes are lost.
- cnt never exceeds div_act-1. After a divisor decrease the wrap still occurs, because apply happens only at the wrap.

## Structure
- Shared package/include prescaler_pkg holds:
  - the default widths;
  - the reset-divisor function 2^(k+1).
- One sub-module, prescaler_ch, holds all per-channel state and output logic. It is instantiated N_CH times by a generate loop.
- The top level contains only the write-address decode and the broadcast of en_i/sync_i.

## Test plan
- Reset release, en_i=1, no writes → clk_o[0..3] toggle with periods 2/4/8/16. Each is bit-exact with a 4-bit free-running counter; tick_o[k] pulses every 2^(k+1) cycles.
- Write ch1 div=5 mid-period → pending_o[1]=1 until old /4 wrap. Then clk_o[1] is low 2 cycles, high 3 cycles; tick every 5 cycles; pending_o[1]=0.
- Write ch2 div=0 → after the next wrap, clk_o[2]=0 and tick_o[2]=0 permanently. Then write div=3 → applies the next cycle, giving 3-cycle ticks.
- Divisors 3/6/7/1 loaded, sync_i pulse → the cycle after sync all cnt=0. The first ticks occur 3/6/7/1 cycles later (ch3 ticks every cycle), and there is no tick in the sync cycle itself.
- en_i low for 10 cycles mid-period → no ticks and clk_o frozen. On resume, the period completes with the remaining count; a write during the freeze stays pending until the wrap.
- Write to cfg_ch_i=N_CH (CH_W permitting) → no state change. Async reset during pending write → pending_o=0 and reset divisors restored.
